// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request/grant bundle between the requesters and the
// round-robin select arbiter that steers mux_bus_prm.
//   master modport: the arbiter (samples req, drives gnt/sel/vld)
//   slave modport : a requester-side block (drives req, observes grant)
interface rr_sel_arbiter_if #(
    parameter int SEL_WIDTH = 2
);
    localparam int N = 2 ** SEL_WIDTH;

    logic [N-1:0]         req;
    logic [N-1:0]         gnt;
    logic [SEL_WIDTH-1:0] sel;
    logic                 vld;

    modport master (
        input  req,
        output gnt,
        output sel,
        output vld
    );

    modport slave (
        output req,
        input  gnt,
        input  sel,
        input  vld
    );
endinterface

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter producing the select code for the
// parameterized bus mux. One request per mux channel, one-hot grant plus
// binary select, grant held until the owner drops its request.
// Optional feature macro: RR_SEL_ARBITER_TIMEOUT_EN
//   defined   -> a hold counter forces rotation after MAX_HOLD grant cycles
//                whenever another channel is waiting
//   undefined -> no counter; a grant is kept until the owner releases it
// All outputs come straight from registers; reset is synchronous, active high.
module rr_sel_arbiter #(
    parameter int SEL_WIDTH = 2,
    parameter int MAX_HOLD  = 8
) (
    input logic               clk,
    input logic               rst,
    rr_sel_arbiter_if.master  bus
);
    localparam int N = 2 ** SEL_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [SEL_WIDTH-1:0] PTR_ONE = SEL_WIDTH'(1);

    if (MAX_HOLD < 1) begin : gBadMaxHold
        $error("rr_sel_arbiter: MAX_HOLD must be at least 1");
    end

    // Convert a channel index into its one-hot position.
    function automatic logic [N-1:0] toOneHot(input logic [SEL_WIDTH-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Scan start, start+1, ... (wrapping modulo N) and return {found, index}
    // of the first set bit in mask.
    function automatic logic [SEL_WIDTH:0] findWinner(
        input logic [N-1:0]         mask,
        input logic [SEL_WIDTH-1:0] start
    );
        logic                 found;
        logic [SEL_WIDTH-1:0] idx;
        logic [SEL_WIDTH-1:0] win;
        found = 1'b0;
        win   = start;
        for (int i = 0; i < N; i++) begin
            idx = start + SEL_WIDTH'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [0:0]           state_q, state_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [N-1:0]         gnt_q, gnt_d;

`ifdef RR_SEL_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             holdExpired;

    assign holdExpired = (holdCnt_q == CNT_MAX);
`endif

    logic [N-1:0]         ownerMask;
    logic                 ownerReq;
    logic [SEL_WIDTH-1:0] nextPtr;
    logic [SEL_WIDTH-1:0] searchPtr;
    logic [N-1:0]         searchMask;
    logic                 winFound;
    logic [SEL_WIDTH-1:0] winSel;

    // While granting, the search starts just past the owner and never picks
    // the owner itself, so a handover (release or timeout) always rotates.
    // In IDLE the search starts at the stored pointer over all requests.
    assign ownerMask  = toOneHot(sel_q);
    assign ownerReq   = |(bus.req & ownerMask);
    assign nextPtr    = sel_q + PTR_ONE;
    assign searchPtr  = (state_q == ST_GRANT) ? nextPtr : ptr_q;
    assign searchMask = (state_q == ST_GRANT) ? (bus.req & ~ownerMask) : bus.req;
    assign {winFound, winSel} = findWinner(searchMask, searchPtr);

    // Next-state logic: grant from idle, hand over on release or timeout,
    // otherwise keep the current owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
        holdCnt_d = holdCnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (winFound) begin
                    state_d = ST_GRANT;
                    sel_d   = winSel;
                    gnt_d   = toOneHot(winSel);
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                    holdCnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!ownerReq) begin
                    ptr_d = nextPtr;
                    if (winFound) begin
                        sel_d = winSel;
                        gnt_d = toOneHot(winSel);
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                        holdCnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
                else if (holdExpired && winFound) begin
                    ptr_d     = nextPtr;
                    sel_d     = winSel;
                    gnt_d     = toOneHot(winSel);
                    holdCnt_d = '0;
                end else if (!holdExpired) begin
                    holdCnt_d = holdCnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
            holdCnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
            holdCnt_q <= holdCnt_d;
`endif
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.sel = sel_q;
    assign bus.vld = (state_q == ST_GRANT);

    // Grant is one-hot or empty, valid mirrors it, and sel names the owner.
    gntOneHot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    vldMatchesGnt: assert property (@(posedge clk) disable iff (rst)
        bus.vld == (gnt_q != '0));
    selMatchesGnt: assert property (@(posedge clk) disable iff (rst)
        bus.vld |-> (gnt_q == toOneHot(sel_q)));
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed stimulus with hand-computed expectations for
// rr_sel_arbiter (SEL_WIDTH=2, MAX_HOLD=4). Expectations follow the build:
// with RR_SEL_ARBITER_TIMEOUT_EN the contended owner rotates every 4 cycles.
module tb_rr_sel_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_sel_arbiter_if #(.SEL_WIDTH(2)) bus ();

    rr_sel_arbiter #(
        .SEL_WIDTH (2),
        .MAX_HOLD  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         step;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   errorCount = 0;
    int   checkCount = 0;
    int   stepCount  = 0;

    // Drive one cycle of inputs and queue what the outputs must be after
    // the next rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [3:0] eg, input logic [1:0] es,
                                 input logic ev);
        exp_t e;
        rst     = r;
        bus.req = rq;
        @(posedge clk);
        e.step = stepCount;
        e.gnt  = eg;
        e.sel  = es;
        e.vld  = ev;
        expQ.push_back(e);
        stepCount++;
        #1;
    endtask

    // Compare the DUT outputs against one queued expectation.
    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (bus.gnt !== e.gnt) begin
            errorCount++;
            $display("[TB] FAIL gnt step %0d: got %b expected %b", e.step, bus.gnt, e.gnt);
        end
        checkCount++;
        if (bus.sel !== e.sel) begin
            errorCount++;
            $display("[TB] FAIL sel step %0d: got %0d expected %0d", e.step, bus.sel, e.sel);
        end
        checkCount++;
        if (bus.vld !== e.vld) begin
            errorCount++;
            $display("[TB] FAIL vld step %0d: got %b expected %b", e.step, bus.vld, e.vld);
        end
    endtask

    // Monitor: outputs settle after the rising edge and are sampled on the
    // falling edge, consuming one expectation per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput(monExp);
            end
        end
    end

    logic [1:0] tOwner;

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;

        $display("[TB] reset with all requests high");
        applyStimulus(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        $display("[TB] single requester");
        applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);

        $display("[TB] back-to-back rotation");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1);
        applyStimulus(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1);
        applyStimulus(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);

        $display("[TB] pointer wrap");
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0);
        applyStimulus(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
        applyStimulus(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        $display("[TB] contended hold");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
`ifdef RR_SEL_ARBITER_TIMEOUT_EN
            tOwner = (((i / 4) % 2) == 0) ? 2'd0 : 2'd1;
`else
            tOwner = 2'd0;
`endif
            applyStimulus(1'b0, 4'b0011, 4'b0001 << tOwner, tOwner, 1'b1);
        end
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

        $display("[TB] reset mid-grant");
        applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);

        $display("[TB] release with simultaneous new request");
        applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);

        $display("[TB] drop and re-raise gets no priority");
        applyStimulus(1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b0110, 4'b0100, 2'd2, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        checkCount++;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
